// File: rtl/des_decrypt_core.sv
// Iterative DES decryption: one Feistel round per clock, 16 rounds per block.
// The key schedule runs backwards (K16..K1) by rotating C/D right after each round.
module des_decrypt_core #(
    parameter bit pCHECK_PARITY = 1'b1
) (
    input  logic        wClk,
    input  logic        wResetN,
    input  logic        wInValid,
    output logic        wInReady,
    input  logic [63:0] wCipherText,
    input  logic [63:0] wKey,
    output logic        wOutValid,
    input  logic        wOutReady,
    output logic [63:0] wPlainText,
    output logic        wKeyParityErr,
    output logic        wBusy
);

    // Permutation tables hold DES bit numbers (1 = MSB), left-aligned and zero padded.
    localparam logic [511:0] IP_T = {
        8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,
        8'd60, 8'd52, 8'd44, 8'd36, 8'd28, 8'd20, 8'd12, 8'd4,
        8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6,
        8'd64, 8'd56, 8'd48, 8'd40, 8'd32, 8'd24, 8'd16, 8'd8,
        8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,
        8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
        8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,
        8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7};

    localparam logic [511:0] FP_T = {
        8'd40, 8'd8, 8'd48, 8'd16, 8'd56, 8'd24, 8'd64, 8'd32,
        8'd39, 8'd7, 8'd47, 8'd15, 8'd55, 8'd23, 8'd63, 8'd31,
        8'd38, 8'd6, 8'd46, 8'd14, 8'd54, 8'd22, 8'd62, 8'd30,
        8'd37, 8'd5, 8'd45, 8'd13, 8'd53, 8'd21, 8'd61, 8'd29,
        8'd36, 8'd4, 8'd44, 8'd12, 8'd52, 8'd20, 8'd60, 8'd28,
        8'd35, 8'd3, 8'd43, 8'd11, 8'd51, 8'd19, 8'd59, 8'd27,
        8'd34, 8'd2, 8'd42, 8'd10, 8'd50, 8'd18, 8'd58, 8'd26,
        8'd33, 8'd1, 8'd41, 8'd9,  8'd49, 8'd17, 8'd57, 8'd25};

    localparam logic [511:0] E_T = {
        8'd32, 8'd1,  8'd2,  8'd3,  8'd4,  8'd5,  8'd4,  8'd5,
        8'd6,  8'd7,  8'd8,  8'd9,  8'd8,  8'd9,  8'd10, 8'd11,
        8'd12, 8'd13, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17,
        8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd21, 8'd20, 8'd21,
        8'd22, 8'd23, 8'd24, 8'd25, 8'd24, 8'd25, 8'd26, 8'd27,
        8'd28, 8'd29, 8'd28, 8'd29, 8'd30, 8'd31, 8'd32, 8'd1,
        128'd0};

    localparam logic [511:0] P_T = {
        8'd16, 8'd7,  8'd20, 8'd21, 8'd29, 8'd12, 8'd28, 8'd17,
        8'd1,  8'd15, 8'd23, 8'd26, 8'd5,  8'd18, 8'd31, 8'd10,
        8'd2,  8'd8,  8'd24, 8'd14, 8'd32, 8'd27, 8'd3,  8'd9,
        8'd19, 8'd13, 8'd30, 8'd6,  8'd22, 8'd11, 8'd4,  8'd25,
        256'd0};

    localparam logic [511:0] PC1_T = {
        8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,
        8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
        8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27,
        8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
        8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15,
        8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
        8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29,
        8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4,
        64'd0};

    localparam logic [511:0] PC2_T = {
        8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,  8'd3,  8'd28,
        8'd15, 8'd6,  8'd21, 8'd10, 8'd23, 8'd19, 8'd12, 8'd4,
        8'd26, 8'd8,  8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
        8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55, 8'd30, 8'd40,
        8'd51, 8'd45, 8'd33, 8'd48, 8'd44, 8'd49, 8'd39, 8'd56,
        8'd34, 8'd53, 8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32,
        128'd0};

    // S-boxes: 64 nibbles each, entry index = {row, col}, first nibble = entry 0.
    localparam logic [255:0] S1 = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    localparam logic [255:0] S2 = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    localparam logic [255:0] S3 = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    localparam logic [255:0] S4 = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    localparam logic [255:0] S5 = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    localparam logic [255:0] S6 = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    localparam logic [255:0] S7 = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    localparam logic [255:0] S8 = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    // Generic bit gather: output bits come out MSB-first, right-aligned in the result.
    function automatic logic [63:0] permute(input logic [63:0] x, input logic [511:0] tbl,
                                            input logic [7:0] in_w, input int n_out);
        logic [63:0]  y;
        logic [511:0] t;
        y = '0;
        t = tbl;
        for (int k = 0; k < 64; k++) begin
            if (k < n_out) begin
                y = {y[62:0], x[6'(in_w - t[511:504])]};
                t = t << 8;
            end
        end
        return y;
    endfunction

    function automatic logic [3:0] sbox(input logic [255:0] tbl, input logic [5:0] x);
        logic [255:0] sh;
        sh = tbl << {x[5], x[0], x[4:1], 2'b00};
        return sh[255:252];
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        x = 48'(permute({32'd0, r}, E_T, 8'd32, 48)) ^ k;
        s = {sbox(S1, x[47:42]), sbox(S2, x[41:36]), sbox(S3, x[35:30]), sbox(S4, x[29:24]),
             sbox(S5, x[23:18]), sbox(S6, x[17:12]), sbox(S7, x[11:6]),  sbox(S8, x[5:0])};
        return 32'(permute({32'd0, s}, P_T, 8'd32, 32));
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] v, input logic one);
        return one ? {v[0], v[27:1]} : {v[1:0], v[27:2]};
    endfunction

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] lft, rgt;
    logic [27:0] c_half, d_half;
    logic        in_ready, out_valid, busy, par_err;
    logic [47:0] subkey;
    logic [31:0] f_out;
    logic        rot_one;
    logic [7:0]  byte_odd;
    logic        key_bad;

    for (genvar b = 0; b < 8; b++) begin : g_par
        assign byte_odd[b] = ^wKey[8*b+7:8*b];
    end
    assign key_bad = pCHECK_PARITY && !(&byte_odd);

    assign subkey  = 48'(permute({8'd0, c_half, d_half}, PC2_T, 8'd56, 48));
    assign f_out   = feistel(rgt, subkey);
    // Reverse shift schedule s[17-cnt]: single-bit steps fall on rounds 1, 8, 15 and 16.
    assign rot_one = (cnt == 5'd1) || (cnt == 5'd8) || (cnt == 5'd15) || (cnt == 5'd16);

    always_ff @(posedge wClk or negedge wResetN) begin
        if (!wResetN) begin
            state     <= IDLE;
            cnt       <= '0;
            lft       <= '0;
            rgt       <= '0;
            c_half    <= '0;
            d_half    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (wInValid) begin
                    {lft, rgt}       <= permute(wCipherText, IP_T, 8'd64, 64);
                    {c_half, d_half} <= 56'(permute(wKey, PC1_T, 8'd64, 56));
                    cnt      <= 5'd1;
                    par_err  <= key_bad;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    state    <= ROUND;
                end
                ROUND: begin
                    lft    <= rgt;
                    rgt    <= lft ^ f_out;
                    c_half <= rotr(c_half, rot_one);
                    d_half <= rotr(d_half, rot_one);
                    if (cnt == 5'd16) begin
                        cnt       <= '0;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                DONE: if (wOutReady) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wInReady      = in_ready;
    assign wOutValid     = out_valid;
    assign wBusy         = busy;
    assign wKeyParityErr = par_err;
    // The final swap is undone by reading R before L.
    assign wPlainText    = permute({rgt, lft}, FP_T, 8'd64, 64);

endmodule

// File: tb/tb_des_decrypt_core.sv
// Bench for des_decrypt_core: a textbook DES model (forward key schedule, reversed subkeys)
// plus a transaction-level timing model, compared against the DUT every falling edge.
module tb_des_decrypt_core;

    logic        wClk = 1'b0;
    logic        wResetN, wInValid, wInReady, wOutValid, wOutReady, wKeyParityErr, wBusy;
    logic [63:0] wCipherText, wKey, wPlainText;
    int tests = 0;
    int fails = 0;

    always #5 wClk = ~wClk;

    des_decrypt_core #(.pCHECK_PARITY(1'b1)) dut (
        .wClk(wClk), .wResetN(wResetN), .wInValid(wInValid), .wInReady(wInReady),
        .wCipherText(wCipherText), .wKey(wKey), .wOutValid(wOutValid), .wOutReady(wOutReady),
        .wPlainText(wPlainText), .wKeyParityErr(wKeyParityErr), .wBusy(wBusy));

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] CT_A  = 64'h85E813540F0AB405;
    localparam logic [63:0] PT_A  = 64'h0123456789ABCDEF;
    localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;
    localparam logic [63:0] PT_B  = 64'h8787878787878787;
    localparam logic [63:0] KEY_P = 64'h133457799BBCDFF0;

    localparam int IP_T[64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
        62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1,
        59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T[64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
        38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28,
        35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T[48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
        16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T[32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
        2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int PC1_T[56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
        10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
        7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T[48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
        16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int SH[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int SB[8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s, p;
        int six, row, col;
        for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
        e = e ^ k;
        for (int b = 0; b < 8; b++) begin
            six = int'(e[47-6*b -: 6]);
            row = ((six >> 5) & 1) * 2 + (six & 1);
            col = (six >> 1) & 15;
            s[31-4*b -: 4] = 4'(SB[b][row*16+col]);
        end
        for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
        return p;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] v, input int n);
        return (v << n) | (v >> (28 - n));
    endfunction

    // Textbook decryption: forward schedule K1..K16, then apply them in reverse.
    function automatic logic [63:0] des_dec(input logic [63:0] ct, input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks[16];
        logic [63:0] x, pre, out;
        logic [31:0] l, r, t;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int n = 0; n < 16; n++) begin
            c = rotl(c, SH[n]);
            d = rotl(d, SH[n]);
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[n][47-i] = cd[56-PC2_T[i]];
        end
        for (int i = 0; i < 64; i++) x[63-i] = ct[64-IP_T[i]];
        l = x[63:32];
        r = x[31:0];
        for (int n = 15; n >= 0; n--) begin
            t = r;
            r = l ^ m_f(r, ks[n]);
            l = t;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) out[63-i] = pre[64-FP_T[i]];
        return out;
    endfunction

    function automatic logic par_bad(input logic [63:0] key);
        for (int b = 0; b < 8; b++)
            if ($countones(key[8*b +: 8]) % 2 == 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: idle -> 16 busy cycles -> valid until accepted.
    logic        m_idle  = 1'b1;
    int          m_left  = 0;
    logic        m_valid = 1'b0;
    logic [63:0] m_pt    = '0;
    logic        m_par   = 1'b0;

    always @(posedge wClk or negedge wResetN) begin
        if (!wResetN) begin
            m_idle <= 1'b1; m_left <= 0; m_valid <= 1'b0; m_pt <= '0; m_par <= 1'b0;
        end else if (m_idle) begin
            if (wInValid) begin
                m_pt   <= des_dec(wCipherText, wKey);
                m_par  <= par_bad(wKey);
                m_left <= 16;
                m_idle <= 1'b0;
            end
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_valid <= 1'b1;
        end else if (wOutReady) begin
            m_valid <= 1'b0;
            m_idle  <= 1'b1;
        end
    end

    always @(negedge wClk) begin
        check("in_ready", wInReady, m_idle);
        check("busy", wBusy, m_left != 0);
        check("out_valid", wOutValid, m_valid);
        if (m_valid) begin
            check("plaintext", wPlainText, m_pt);
            check("parity_err", wKeyParityErr, m_par);
        end
        if (!wResetN) begin
            check("rst_plaintext", wPlainText, 64'd0);
            check("rst_parity", wKeyParityErr, 1'b0);
        end
    end

    task automatic send(input logic [63:0] ct, input logic [63:0] key);
        @(negedge wClk);
        wCipherText = ct;
        wKey        = key;
        wInValid    = 1'b1;
        @(posedge wClk);
        @(negedge wClk);
        wInValid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!wOutValid && n < 40) begin
            @(negedge wClk);
            n++;
        end
    endtask

    int n;

    initial begin
        wResetN = 1'b0; wInValid = 1'b0; wOutReady = 1'b1; wCipherText = '0; wKey = '0;
        check("model_A", des_dec(CT_A, KEY_A), PT_A);
        check("model_B", des_dec(64'd0, KEY_B), PT_B);
        check("model_par_ok", par_bad(KEY_A), 1'b0);
        check("model_par_bad", par_bad(KEY_P), 1'b1);
        repeat (3) @(negedge wClk);
        check("rst_valid", wOutValid, 1'b0);
        check("rst_busy", wBusy, 1'b0);
        wResetN = 1'b1;
        @(negedge wClk);
        check("ready_after_rst", wInReady, 1'b1);

        send(CT_A, KEY_A);
        wait_valid(n);
        check("latency_A", n, 16);
        check("pt_A", wPlainText, PT_A);
        check("par_A", wKeyParityErr, 1'b0);
        @(negedge wClk);

        // Stall for 10 cycles with a competing request that must be ignored
        wOutReady = 1'b0;
        send(64'd0, KEY_B);
        wait_valid(n);
        check("latency_B", n, 16);
        check("pt_B", wPlainText, PT_B);
        wCipherText = CT_A; wKey = KEY_A; wInValid = 1'b1;
        repeat (10) begin
            @(negedge wClk);
            check("stall_valid", wOutValid, 1'b1);
            check("stall_pt", wPlainText, PT_B);
            check("stall_ready", wInReady, 1'b0);
        end
        wInValid = 1'b0; wOutReady = 1'b1;
        @(negedge wClk);
        check("valid_drop", wOutValid, 1'b0);

        // Bad parity only in a parity bit: same subkeys, so the same plaintext
        send(CT_A, KEY_P);
        wait_valid(n);
        check("pt_P", wPlainText, PT_A);
        check("par_P", wKeyParityErr, 1'b1);
        @(negedge wClk);

        // Reset during round 7 with the parity flag set
        send(CT_A, KEY_P);
        repeat (6) @(posedge wClk);
        #2 wResetN = 1'b0;
        #1;
        check("midrst_valid", wOutValid, 1'b0);
        check("midrst_busy", wBusy, 1'b0);
        check("midrst_pt", wPlainText, 64'd0);
        check("midrst_par", wKeyParityErr, 1'b0);
        repeat (2) @(negedge wClk);
        wResetN = 1'b1;
        send(CT_A, KEY_A);
        wait_valid(n);
        check("latency_after_rst", n, 16);
        check("pt_after_rst", wPlainText, PT_A);
        @(negedge wClk);

        // Back-to-back: second request held valid, accepted right after IDLE re-entry
        @(negedge wClk);
        wCipherText = 64'd0; wKey = KEY_B; wInValid = 1'b1;
        @(posedge wClk);
        @(negedge wClk);
        wCipherText = CT_A; wKey = KEY_A;
        wait_valid(n);
        check("latency_b2b1", n, 16);
        check("pt_b2b1", wPlainText, PT_B);
        n = 0;
        do begin
            @(negedge wClk);
            n++;
        end while (!wOutValid && n < 40);
        wInValid = 1'b0;
        check("gap_b2b", n, 18);
        check("pt_b2b2", wPlainText, PT_A);
        repeat (3) @(negedge wClk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
